// File: rtl/rtc_bus_seq_if.sv
// Multiplexed address/data bus of the external RTC.
// The sequencer owns the bus (master); the RTC model or pad ring is the slave.
interface rtc_bus_seq_if;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_sel;
  logic [7:0] ad_in;

  modport master (
    output ad_out, ad_oe, cs_n, rd_n, wr_n, ad_sel,
    input  ad_in
  );

  modport slave (
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, ad_sel,
    output ad_in
  );
endinterface

// File: rtl/rtc_bus_seq.sv
// rtc_bus_seq: sequences every access on the RTC multiplexed bus.
//   - power-on init: two writes to INIT_ADDR (INIT_VAL0, then INIT_VAL1)
//   - read burst of NUM_REGS registers (RD_BASE+i) on each v_sync rising edge
//   - single edit write of the last captured wr_addr/wr_data
// Optional build macro RTC_LATCH_CMD_EN: each read burst is preceded by a
// latch command write (8'hF0 to 8'hF0) that freezes the RTC time registers.
//
// Handshake: rd_valid is a one-cycle strobe qualifying rd_idx/rd_data, with no
// backpressure (the consumer must take it that cycle). wr_req is a one-cycle
// request pulse with no acknowledge; a later wr_req before service replaces
// the pending one. v_sync rising edges collapse into one pending burst.
module rtc_bus_seq #(
  parameter int         NUM_REGS  = 9,
  parameter int         PHASE_CYC = 8,
  parameter logic [7:0] RD_BASE   = 8'h21,
  parameter logic [7:0] INIT_ADDR = 8'h02,
  parameter logic [7:0] INIT_VAL0 = 8'h10,
  parameter logic [7:0] INIT_VAL1 = 8'h00
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            v_sync,
  input  logic                            wr_req,
  input  logic [7:0]                      wr_addr,
  input  logic [7:0]                      wr_data,
  rtc_bus_seq_if.master                   bus,
  output logic [$clog2(NUM_REGS+1)-1:0]   rd_idx,
  output logic [7:0]                      rd_data,
  output logic                            rd_valid,
  output logic                            busy,
  output logic                            init_done,
  output logic [1:0]                      dbg_state
);

  localparam int IDX_W = $clog2(NUM_REGS + 1);
  localparam int CNT_W = $clog2(PHASE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

`ifdef RTC_LATCH_CMD_EN
  localparam bit LATCH_CMD = 1'b1;
`else
  localparam bit LATCH_CMD = 1'b0;
`endif

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ, ST_WRITE} state_t;
  typedef enum logic [1:0] {PH_ADDR, PH_GAP1, PH_DATA, PH_GAP2} phase_t;

  // Position registers describe the access slot that the next clock edge
  // puts on the bus; bus outputs are registered decodes of this position.
  state_t           state;
  phase_t           phase;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cmd_act;

  logic             vs_q;
  logic             rd_pend;
  logic             wr_pend;
  logic [7:0]       wa_q;
  logic [7:0]       wd_q;
  logic [7:0]       acc_wa;
  logic [7:0]       acc_wd;

  logic             acc_is_wr;
  logic [7:0]       acc_a;
  logic [7:0]       acc_d;
  logic             vs_edge;
  logic             cnt_last;

  assign vs_edge   = v_sync & ~vs_q;
  assign cnt_last  = (cnt == CNT_LAST);
  assign dbg_state = state;

  // Address, data and direction of the access currently being sequenced.
  always_comb begin
    acc_is_wr = 1'b1;
    acc_a     = 8'h00;
    acc_d     = 8'h00;
    case (state)
      ST_INIT: begin
        acc_a = INIT_ADDR;
        acc_d = (idx == '0) ? INIT_VAL0 : INIT_VAL1;
      end
      ST_WRITE: begin
        acc_a = acc_wa;
        acc_d = acc_wd;
      end
      ST_READ: begin
        if (cmd_act) begin
          acc_a = 8'hF0;
          acc_d = 8'hF0;
        end else begin
          acc_is_wr = 1'b0;
          acc_a     = RD_BASE + 8'(idx);
        end
      end
      default: acc_is_wr = 1'b0;
    endcase
  end

  // Sequencer FSM: bus drive, read capture, access stepping and request flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      phase      <= PH_ADDR;
      cnt        <= '0;
      idx        <= '0;
      cmd_act    <= 1'b0;
      vs_q       <= 1'b0;
      rd_pend    <= 1'b0;
      wr_pend    <= 1'b0;
      wa_q       <= 8'h00;
      wd_q       <= 8'h00;
      acc_wa     <= 8'h00;
      acc_wd     <= 8'h00;
      bus.ad_out <= 8'h00;
      bus.ad_oe  <= 1'b0;
      bus.cs_n   <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.ad_sel <= 1'b0;
      rd_idx     <= '0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      busy       <= 1'b1;
      init_done  <= 1'b0;
    end else begin
      vs_q     <= v_sync;
      rd_valid <= 1'b0;

      // Idle bus levels unless the current slot is an ADDR or DATA phase.
      bus.ad_out <= 8'h00;
      bus.ad_oe  <= 1'b0;
      bus.cs_n   <= 1'b1;
      bus.rd_n   <= 1'b1;
      bus.wr_n   <= 1'b1;
      bus.ad_sel <= 1'b0;
      if (state != ST_IDLE) begin
        case (phase)
          PH_ADDR: begin
            bus.cs_n   <= 1'b0;
            bus.wr_n   <= 1'b0;
            bus.ad_oe  <= 1'b1;
            bus.ad_out <= acc_a;
          end
          PH_DATA: begin
            bus.cs_n   <= 1'b0;
            bus.ad_sel <= 1'b1;
            if (acc_is_wr) begin
              bus.wr_n   <= 1'b0;
              bus.ad_oe  <= 1'b1;
              bus.ad_out <= acc_d;
            end else begin
              bus.rd_n   <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      // The first GAP2 slot edge closes the last DATA cycle: sample ad_in.
      if (state == ST_READ && !cmd_act && phase == PH_GAP2 && cnt == '0) begin
        rd_data  <= bus.ad_in;
        rd_idx   <= idx;
        rd_valid <= 1'b1;
      end

      if (state == ST_IDLE) begin
        phase <= PH_ADDR;
        cnt   <= '0;
        if (wr_pend) begin
          state   <= ST_WRITE;
          wr_pend <= 1'b0;
          acc_wa  <= wa_q;
          acc_wd  <= wd_q;
          busy    <= 1'b1;
        end else if (rd_pend) begin
          state   <= ST_READ;
          rd_pend <= 1'b0;
          idx     <= '0;
          cmd_act <= LATCH_CMD;
          busy    <= 1'b1;
        end
      end else if (!cnt_last) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt   <= '0;
        phase <= phase_t'(phase + 2'd1);
        if (phase == PH_GAP2) begin
          case (state)
            ST_INIT: begin
              if (idx == '0) begin
                idx <= IDX_W'(1);
              end else begin
                idx       <= '0;
                state     <= ST_IDLE;
                busy      <= 1'b0;
                init_done <= 1'b1;
              end
            end
            ST_READ: begin
              if (cmd_act) begin
                cmd_act <= 1'b0;
              end else if (idx == IDX_LAST) begin
                idx   <= '0;
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
            default: begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end

      // New requests win over the clear on state entry in the same cycle.
      if (vs_edge) begin
        rd_pend <= 1'b1;
      end
      if (wr_req) begin
        wr_pend <= 1'b1;
        wa_q    <= wr_addr;
        wd_q    <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Bench for rtc_bus_seq: default instance (9 regs, 8-cycle phases) plus a
// small instance (1 reg, 2-cycle phases). RTC answers a read of address a
// with a ^ 8'hA5.
module tb_rtc_bus_seq;

`ifdef RTC_LATCH_CMD_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int BURST0   = (9 + LAT) * 32;
  localparam int BURST1   = (1 + LAT) * 8;
  localparam int FIRST_RV = 27 + LAT * 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       v_sync0 = 1'b0, wr_req0 = 1'b0;
  logic [7:0] wr_addr0 = 8'h00, wr_data0 = 8'h00;
  logic [3:0] rd_idx0;
  logic [7:0] rd_data0;
  logic       rd_valid0, busy0, init_done0;
  logic [1:0] dbg0;

  logic       v_sync1 = 1'b0, wr_req1 = 1'b0;
  logic [7:0] wr_addr1 = 8'h00, wr_data1 = 8'h00;
  logic [0:0] rd_idx1;
  logic [7:0] rd_data1;
  logic       rd_valid1, busy1, init_done1;
  logic [1:0] dbg1;

  rtc_bus_seq_if bus0 ();
  rtc_bus_seq_if bus1 ();

  rtc_bus_seq dut0 (
    .clk(clk), .reset(reset), .v_sync(v_sync0), .wr_req(wr_req0),
    .wr_addr(wr_addr0), .wr_data(wr_data0), .bus(bus0),
    .rd_idx(rd_idx0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .busy(busy0), .init_done(init_done0), .dbg_state(dbg0)
  );

  rtc_bus_seq #(.NUM_REGS(1), .PHASE_CYC(2)) dut1 (
    .clk(clk), .reset(reset), .v_sync(v_sync1), .wr_req(wr_req1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .bus(bus1),
    .rd_idx(rd_idx1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .busy(busy1), .init_done(init_done1), .dbg_state(dbg1)
  );

  // ---------------- RTC bus models ----------------
  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  logic [7:0] lat0 = 8'h00, lat1 = 8'h00;
  always @(negedge clk) begin
    if (!bus0.cs_n && !bus0.ad_sel) lat0 <= bus0.ad_out;
    if (!bus1.cs_n && !bus1.ad_sel) lat1 <= bus1.ad_out;
  end
  assign bus0.ad_in = rtc_val(lat0);
  assign bus1.ad_in = rtc_val(lat1);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int rv_cyc_q[$];
  logic [11:0] exp_q[$];
  logic [15:0] exp_wr_q[$];
  logic [8:0]  exp1_q[$];
  logic in_wd = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One cycle: wait for the falling edge, then run all bus/strobe monitors.
  task automatic tick();
    logic [11:0] e;
    logic [15:0] w;
    logic [8:0]  e1;
    @(negedge clk);
    cyc++;
    if (rd_valid0) begin
      rv_cnt++;
      rv_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_unexpected: got idx %0d data %0h expected no rd_valid", rd_idx0, rd_data0);
      end else begin
        e = exp_q.pop_front();
        chk("rd0", {20'd0, rd_idx0, rd_data0}, {20'd0, e});
      end
    end
    if (rd_valid1) begin
      if (exp1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd1_unexpected: got idx %0d data %0h expected no rd_valid", rd_idx1, rd_data1);
      end else begin
        e1 = exp1_q.pop_front();
        chk("rd1", {23'd0, rd_idx1, rd_data1}, {23'd0, e1});
      end
    end
    if (!bus0.cs_n && bus0.ad_sel && !bus0.wr_n) begin
      if (!in_wd) begin
        in_wd = 1'b1;
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr0_unexpected: got addr %0h data %0h expected no write", lat0, bus0.ad_out);
        end else begin
          w = exp_wr_q.pop_front();
          chk("wr0_addr_data", {16'd0, lat0, bus0.ad_out}, {16'd0, w});
          chk("wr0_oe", {31'd0, bus0.ad_oe}, 32'd1);
        end
      end
    end else begin
      in_wd = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input int sel, input int limit, output int n);
    bit started;
    logic b;
    started = 1'b0;
    n = 0;
    for (int t = 0; t < limit; t++) begin
      tick();
      b = (sel == 1) ? busy1 : busy0;
      if (b) begin
        started = 1'b1;
        n++;
      end else if (started) begin
        return;
      end
    end
    checks++; errors++;
    $display("FAIL busy_timeout%0d: got %0d busy cycles expected idle within %0d", sel, n, limit);
  endtask

  task automatic push_burst0();
    if (LAT == 1) exp_wr_q.push_back(16'hF0F0);
    for (int i = 0; i < 9; i++) exp_q.push_back({4'(i), rtc_val(8'h21 + 8'(i))});
  endtask

  task automatic push_init0();
    exp_wr_q.push_back(16'h0210);
    exp_wr_q.push_back(16'h0200);
  endtask

  task automatic pulse_vsync0();
    v_sync0 = 1'b1;
    tick();
    v_sync0 = 1'b0;
    tick();
  endtask

  typedef struct {
    int         k;
    logic       cs_n, rd_n, wr_n, ad_sel, ad_oe;
    logic [7:0] ad_out;
    logic       busy, init_done;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n;
    int c0;
    int k;
    // bus snapshot after the k-th clock edge following reset release
    vecs[0]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[1]  = '{8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[2]  = '{9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{17, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0};
    vecs[5]  = '{24, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0};
    vecs[6]  = '{25, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[9]  = '{49, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{63, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{65, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    // ---- reset values ----
    repeat (3) tick();
    chk("rst_bus", {26'd0, bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_sel, bus0.ad_oe, 1'b0}, 32'h38);
    chk("rst_ad_out", {24'd0, bus0.ad_out}, 32'h0);
    chk("rst_rd", {19'd0, rd_valid0, rd_idx0, rd_data0}, 32'h0);
    chk("rst_busy_done", {30'd0, busy0, init_done0}, 32'h2);

    // ---- init sequence ----
    push_init0();
    reset = 1'b0;
    k = 0;
    for (int v = 0; v < 13; v++) begin
      while (k < vecs[v].k) begin
        tick();
        k++;
      end
      chk($sformatf("init_k%0d", vecs[v].k),
          {17'd0, bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_sel, bus0.ad_oe, bus0.ad_out, busy0, init_done0},
          {17'd0, vecs[v].cs_n, vecs[v].rd_n, vecs[v].wr_n, vecs[v].ad_sel, vecs[v].ad_oe,
           vecs[v].ad_out, vecs[v].busy, vecs[v].init_done});
    end
    chk("init_writes_seen", exp_wr_q.size(), 0);
    chk("init_idle_state", {30'd0, dbg0}, 32'd1);
    chk("init1_done", {31'd0, init_done1}, 32'd1);

    // ---- read burst ----
    rv_cnt = 0;
    rv_cyc_q.delete();
    push_burst0();
    c0 = cyc;
    v_sync0 = 1'b1;
    wait_busy(0, 500, n);
    chk("burst_busy_cycles", n, BURST0);
    chk("burst_rv_count", rv_cnt, 9);
    chk("burst_exp_left", exp_q.size(), 0);
    chk("burst_wr_left", exp_wr_q.size(), 0);
    if (rv_cyc_q.size() == 9) begin
      chk("burst_first_latency", rv_cyc_q[0] - c0, FIRST_RV);
      for (int i = 1; i < 9; i++) chk($sformatf("burst_spacing%0d", i), rv_cyc_q[i] - rv_cyc_q[i-1], 32);
    end
    v_sync0 = 1'b0;
    tick();

    // ---- edit write ----
    rv_cnt = 0;
    exp_wr_q.push_back(16'h2345);
    wr_addr0 = 8'h23;
    wr_data0 = 8'h45;
    wr_req0 = 1'b1;
    tick();
    wr_req0 = 1'b0;
    wait_busy(0, 100, n);
    chk("edit_busy_cycles", n, 32);
    chk("edit_no_rd", rv_cnt, 0);
    chk("edit_wr_left", exp_wr_q.size(), 0);

    // ---- simultaneous write and v_sync edge ----
    rv_cnt = 0;
    exp_wr_q.push_back(16'h7788);
    push_burst0();
    wr_addr0 = 8'h77;
    wr_data0 = 8'h88;
    wr_req0 = 1'b1;
    v_sync0 = 1'b1;
    tick();
    wr_req0 = 1'b0;
    for (int t = 0; t < 200 && exp_wr_q.size() > LAT; t++) tick();
    chk("simul_user_write_seen", {31'd0, exp_wr_q.size() <= LAT}, 32'd1);
    chk("simul_write_before_read", rv_cnt, 0);
    for (int t = 0; t < 600 && (exp_q.size() != 0 || busy0); t++) tick();
    chk("simul_rv_count", rv_cnt, 9);
    chk("simul_exp_left", exp_q.size(), 0);
    v_sync0 = 1'b0;
    tick();

    // ---- three edges during a burst collapse into one more burst ----
    rv_cnt = 0;
    push_burst0();
    push_burst0();
    pulse_vsync0();
    repeat (30) tick();
    pulse_vsync0();
    repeat (30) tick();
    pulse_vsync0();
    repeat (30) tick();
    pulse_vsync0();
    for (int t = 0; t < 900 && (exp_q.size() != 0 || busy0); t++) tick();
    repeat (60) tick();
    chk("collapse_rv_count", rv_cnt, 18);
    chk("collapse_exp_left", exp_q.size(), 0);
    chk("collapse_idle", {31'd0, busy0}, 32'd0);

    // ---- reset in the middle of read index 4 ----
    rv_cnt = 0;
    push_burst0();
    v_sync0 = 1'b1;
    for (int t = 0; t < 400 && rv_cnt < 4; t++) tick();
    repeat (9) tick();
    chk("prereset_cs_n", {31'd0, bus0.cs_n}, 32'd0);
    reset = 1'b1;
    v_sync0 = 1'b0;
    #1;
    chk("async_reset_levels",
        {24'd0, bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_oe, bus0.ad_sel, busy0, init_done0, rd_valid0},
        32'hE4);
    chk("async_reset_ad_out", {24'd0, bus0.ad_out}, 32'h0);
    exp_q.delete();
    exp_wr_q.delete();
    repeat (3) tick();
    push_init0();
    reset = 1'b0;
    wait_busy(0, 200, n);
    chk("reinit_busy_cycles", n, 63);
    chk("reinit_done", {31'd0, init_done0}, 32'd1);
    chk("reinit_writes_seen", exp_wr_q.size(), 0);
    repeat (40) tick();
    chk("reset_no_more_rv", rv_cnt, 4);

    // ---- small instance: 1 register, 2-cycle phases ----
    exp1_q.push_back({1'b0, rtc_val(8'h21)});
    v_sync1 = 1'b1;
    wait_busy(1, 100, n);
    chk("small_busy_cycles", n, BURST1);
    tick();
    chk("small_exp_left", exp1_q.size(), 0);
    v_sync1 = 1'b0;

    // ---- report ----
    chk("final_exp_empty", exp_q.size() + exp_wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
